// File: rtl/nn_result_pkg.sv
// Shared types for the NN result collector: word width, FSM states, Flopoco exception codes.
// No logic of its own; the exception classifier is a pure function.
package nn_result_pkg;

    localparam int NN_BIT_WIDTH  = 32;
    localparam int NN_EXTRA_BITS = 2;
    localparam int NN_WORD_W     = NN_BIT_WIDTH + NN_EXTRA_BITS;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_SEND    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    // Inf and NaN mark a result the host should not trust.
    function automatic logic exc_is_bad(input logic [1:0] exc);
        logic bad;
        case (exc)
            EXC_ZERO, EXC_NORMAL: bad = 1'b0;
            default:              bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/nn_word_buffer.sv
// Result word store: DEPTH x W registers, one write port, one combinational read port.
// Cleared by synchronous RESET; no flow control of its own.
module nn_word_buffer
    import nn_result_pkg::*;
#(
    parameter int W     = NN_WORD_W,
    parameter int DEPTH = 3,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/nn_result_collector.sv
// Captures Best_error plus NUM_UNKNOWNS roots after stop_training (or the cycle limit) and streams them out.
// Optional NN_RESULT_EXC_CHECK_EN adds a sticky inf/NaN flag; registered outputs, M_VALID/M_READY backpressure.
module nn_result_collector
    import nn_result_pkg::*;
#(
    parameter int               BIT_WIDTH    = NN_BIT_WIDTH,
    parameter int               EXTRA_BITS   = NN_EXTRA_BITS,
    parameter int               NUM_UNKNOWNS = 2,
    parameter int               CNT_W        = 24,
    parameter logic [CNT_W-1:0] MAX_CYCLES   = CNT_W'(24'hFFFFFF),
    localparam int              W            = BIT_WIDTH + EXTRA_BITS,
    localparam int              IDX_W        = $clog2(NUM_UNKNOWNS + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             STOP_TRAINING,
    input  logic [W-1:0]     BEST_ERROR,
    input  logic [W-1:0]     ROOT_IN,
    input  logic             ROOT_VALID,
    output logic [W-1:0]     M_DATA,
    output logic [IDX_W-1:0] M_IDX,
    output logic             M_VALID,
    input  logic             M_READY,
    output logic             M_LAST,
    output logic             DONE,
    output logic             TIMEOUT,
    output logic [CNT_W-1:0] TRAIN_CYCLES,
    output logic             BAD_RESULT
);

    localparam logic [CNT_W-1:0] LIMIT_M1 = MAX_CYCLES - 1'b1;
    localparam bit               LIMIT_EN = (MAX_CYCLES != '0);
    localparam logic [IDX_W-1:0] LAST_WR  = IDX_W'(NUM_UNKNOWNS - 1);
    localparam logic [IDX_W-1:0] LAST_RD  = IDX_W'(NUM_UNKNOWNS);

    state_t           state, state_nxt;
    logic             stop_d, stop_edge, limit_hit, idle_exit;
    logic             root_wr, last_root, xfer;
    logic [IDX_W-1:0] wr_idx, rd_idx, rd_nxt;
    logic             buf_wr_en;
    logic [IDX_W-1:0] buf_wr_addr;
    logic [W-1:0]     buf_wr_data, buf_rd_data;
    logic             m_valid_nxt, m_last_nxt, done_nxt;
    logic [W-1:0]     m_data_nxt;
    logic [IDX_W-1:0] m_idx_nxt;

    assign stop_edge = STOP_TRAINING & ~stop_d;
    assign limit_hit = LIMIT_EN && (TRAIN_CYCLES == LIMIT_M1);
    assign idle_exit = (state == S_IDLE) && (stop_edge || limit_hit);
    assign root_wr   = (state == S_CAPTURE) && ROOT_VALID;
    assign last_root = root_wr && (wr_idx == LAST_WR);
    assign xfer      = (state == S_SEND) && M_VALID && M_READY;
    // rd_idx parks on the last slot so the index never wraps past N.
    assign rd_nxt    = rd_idx + IDX_W'(xfer && !M_LAST);

    // Slot 0 holds the error word; roots land in 1..N.
    assign buf_wr_en   = idle_exit || root_wr;
    assign buf_wr_addr = idle_exit ? '0 : wr_idx + 1'b1;
    assign buf_wr_data = idle_exit ? BEST_ERROR : ROOT_IN;

    nn_word_buffer #(
        .W     (W),
        .DEPTH (NUM_UNKNOWNS + 1),
        .AW    (IDX_W)
    ) u_buf (
        .CLK     (CLK),
        .RESET   (RESET),
        .wr_en   (buf_wr_en),
        .wr_addr (buf_wr_addr),
        .wr_data (buf_wr_data),
        .rd_addr (rd_nxt),
        .rd_data (buf_rd_data)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (idle_exit) state_nxt = S_CAPTURE;
            S_CAPTURE: if (last_root) state_nxt = S_SEND;
            S_SEND:    if (xfer && M_LAST) state_nxt = S_DONE;
            default:   state_nxt = S_DONE;
        endcase
    end

    // Output values are computed for the next state so the registered outputs line up with it.
    always_comb begin
        m_valid_nxt = 1'b0;
        m_data_nxt  = '0;
        m_idx_nxt   = '0;
        m_last_nxt  = 1'b0;
        done_nxt    = (state_nxt == S_DONE);
        if (state_nxt == S_SEND) begin
            m_valid_nxt = 1'b1;
            m_data_nxt  = buf_rd_data;
            m_idx_nxt   = rd_nxt;
            m_last_nxt  = (rd_nxt == LAST_RD);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stop_d       <= 1'b0;
            wr_idx       <= '0;
            rd_idx       <= '0;
            TRAIN_CYCLES <= '0;
            TIMEOUT      <= 1'b0;
            M_VALID      <= 1'b0;
            M_DATA       <= '0;
            M_IDX        <= '0;
            M_LAST       <= 1'b0;
            DONE         <= 1'b0;
        end else begin
            stop_d <= STOP_TRAINING;
            if ((state == S_IDLE) && !idle_exit && (TRAIN_CYCLES != '1)) begin
                TRAIN_CYCLES <= TRAIN_CYCLES + 1'b1;
            end
            if (idle_exit) begin
                TIMEOUT <= limit_hit && !stop_edge;
            end
            if (root_wr) begin
                wr_idx <= wr_idx + 1'b1;
            end
            rd_idx  <= rd_nxt;
            M_VALID <= m_valid_nxt;
            M_DATA  <= m_data_nxt;
            M_IDX   <= m_idx_nxt;
            M_LAST  <= m_last_nxt;
            DONE    <= done_nxt;
        end
    end

`ifdef NN_RESULT_EXC_CHECK_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            BAD_RESULT <= 1'b0;
        end else if (buf_wr_en && exc_is_bad(buf_wr_data[W-1:W-2])) begin
            BAD_RESULT <= 1'b1;
        end
    end
`else
    assign BAD_RESULT = 1'b0;
`endif

endmodule

// File: tb/tb_nn_result_collector.sv
// Directed bench for nn_result_collector: default-limit instance (d_*) and MAX_CYCLES=50 instance (l_*).
module tb_nn_result_collector;

`ifdef NN_RESULT_EXC_CHECK_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET, STOP_TRAINING, ROOT_VALID, M_READY;
    logic [33:0] BEST_ERROR, ROOT_IN;

    logic [33:0] d_data, l_data;
    logic [1:0]  d_idx, l_idx;
    logic        d_valid, d_last, d_done, d_timeout, d_bad;
    logic        l_valid, l_last, l_done, l_timeout, l_bad;
    logic [23:0] d_cycles, l_cycles;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 CLK = ~CLK;

    nn_result_collector dut (
        .CLK(CLK), .RESET(RESET), .STOP_TRAINING(STOP_TRAINING), .BEST_ERROR(BEST_ERROR),
        .ROOT_IN(ROOT_IN), .ROOT_VALID(ROOT_VALID), .M_DATA(d_data), .M_IDX(d_idx),
        .M_VALID(d_valid), .M_READY(M_READY), .M_LAST(d_last), .DONE(d_done),
        .TIMEOUT(d_timeout), .TRAIN_CYCLES(d_cycles), .BAD_RESULT(d_bad)
    );

    nn_result_collector #(.MAX_CYCLES(24'd50)) dut_lim (
        .CLK(CLK), .RESET(RESET), .STOP_TRAINING(STOP_TRAINING), .BEST_ERROR(BEST_ERROR),
        .ROOT_IN(ROOT_IN), .ROOT_VALID(ROOT_VALID), .M_DATA(l_data), .M_IDX(l_idx),
        .M_VALID(l_valid), .M_READY(M_READY), .M_LAST(l_last), .DONE(l_done),
        .TIMEOUT(l_timeout), .TRAIN_CYCLES(l_cycles), .BAD_RESULT(l_bad)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int k);
        while (cyc < k) tick();
    endtask

    // cyc names the next edge; values read at cyc==k are the outputs "at cycle k".
    task automatic do_reset();
        RESET = 1'b1; STOP_TRAINING = 1'b0; ROOT_VALID = 1'b0; M_READY = 1'b0;
        BEST_ERROR = '0; ROOT_IN = '0;
        tick();
        tick();
        RESET = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", d_valid); end
        n_vec++; if (d_data !== 34'h0) begin n_err++; $display("FAIL reset_data got %h want 0", d_data); end
        n_vec++; if (d_done !== 1'b0 || d_timeout !== 1'b0 || d_last !== 1'b0 || d_bad !== 1'b0) begin
            n_err++; $display("FAIL reset_flags got done=%b to=%b last=%b bad=%b want 0", d_done, d_timeout, d_last, d_bad); end
        n_vec++; if (d_cycles !== 24'd0) begin n_err++; $display("FAIL reset_cycles got %0d want 0", d_cycles); end
        go_to(5);
        n_vec++; if (d_cycles !== 24'd5) begin n_err++; $display("FAIL idle_count got %0d want 5", d_cycles); end
    endtask

    task automatic test_single_run();
        do_reset();
        M_READY = 1'b1;
        go_to(100);
        STOP_TRAINING = 1'b1; BEST_ERROR = 34'h1_3A83_126F;
        tick();
        n_vec++; if (d_cycles !== 24'd100) begin n_err++; $display("FAIL run_cycles got %0d want 100", d_cycles); end
        n_vec++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL run_early_valid got %b want 0", d_valid); end
        tick();
        ROOT_VALID = 1'b1; ROOT_IN = 34'h1_3F80_0000;
        tick();
        ROOT_IN = 34'h1_4000_0000;
        tick();
        ROOT_VALID = 1'b0; ROOT_IN = 34'h0_DEAD_BEEF;
        n_vec++; if (cyc !== 104 || d_valid !== 1'b1 || d_idx !== 2'd0 || d_data !== 34'h1_3A83_126F || d_last !== 1'b0) begin
            n_err++; $display("FAIL run_w0 cyc=%0d got v=%b i=%0d d=%h l=%b want 1/0/13a83126f/0", cyc, d_valid, d_idx, d_data, d_last); end
        tick();
        n_vec++; if (d_valid !== 1'b1 || d_idx !== 2'd1 || d_data !== 34'h1_3F80_0000 || d_last !== 1'b0) begin
            n_err++; $display("FAIL run_w1 got v=%b i=%0d d=%h l=%b want 1/1/13f800000/0", d_valid, d_idx, d_data, d_last); end
        tick();
        n_vec++; if (d_valid !== 1'b1 || d_idx !== 2'd2 || d_data !== 34'h1_4000_0000 || d_last !== 1'b1) begin
            n_err++; $display("FAIL run_w2 got v=%b i=%0d d=%h l=%b want 1/2/140000000/1", d_valid, d_idx, d_data, d_last); end
        tick();
        n_vec++; if (d_done !== 1'b1 || d_valid !== 1'b0 || d_last !== 1'b0) begin
            n_err++; $display("FAIL run_done got done=%b v=%b l=%b want 1/0/0", d_done, d_valid, d_last); end
        n_vec++; if (d_cycles !== 24'd100 || d_timeout !== 1'b0) begin
            n_err++; $display("FAIL run_final got cyc=%0d to=%b want 100/0", d_cycles, d_timeout); end
        n_vec++; if (d_bad !== 1'b0) begin n_err++; $display("FAIL run_bad got %b want 0", d_bad); end
    endtask

    task automatic test_backpressure();
        logic [33:0] words [3];
        logic [5:0]  rdy_pat;
        int          exp_idx;
        words[0] = 34'h1_3A83_126F; words[1] = 34'h1_3F80_0000; words[2] = 34'h1_4000_0000;
        rdy_pat = 6'b110010;
        exp_idx = 0;
        do_reset();
        go_to(100);
        STOP_TRAINING = 1'b1; BEST_ERROR = words[0];
        tick(); tick();
        ROOT_VALID = 1'b1; ROOT_IN = words[1];
        tick();
        ROOT_IN = words[2];
        tick();
        ROOT_VALID = 1'b0;
        for (int i = 0; i < 6; i++) begin
            M_READY = rdy_pat[i];
            n_vec++; if (d_valid !== 1'b1 || d_idx !== exp_idx[1:0] || d_data !== words[exp_idx] || d_last !== (exp_idx == 2)) begin
                n_err++; $display("FAIL bp_word%0d got v=%b i=%0d d=%h want 1/%0d/%h", i, d_valid, d_idx, d_data, exp_idx, words[exp_idx]); end
            tick();
            if (rdy_pat[i]) exp_idx++;
        end
        M_READY = 1'b0;
        n_vec++; if (d_done !== 1'b1 || d_valid !== 1'b0 || cyc !== 110) begin
            n_err++; $display("FAIL bp_done cyc=%0d got done=%b v=%b want 1/0", cyc, d_done, d_valid); end
    endtask

    task automatic test_timeout();
        do_reset();
        BEST_ERROR = 34'h0_4248_0000;
        M_READY = 1'b1;
        go_to(49);
        n_vec++; if (l_timeout !== 1'b0 || l_cycles !== 24'd49) begin
            n_err++; $display("FAIL to_before got to=%b cyc=%0d want 0/49", l_timeout, l_cycles); end
        tick();
        n_vec++; if (l_timeout !== 1'b1 || l_cycles !== 24'd49) begin
            n_err++; $display("FAIL to_capture got to=%b cyc=%0d want 1/49", l_timeout, l_cycles); end
        n_vec++; if (d_timeout !== 1'b0 || d_cycles !== 24'd50) begin
            n_err++; $display("FAIL to_default got to=%b cyc=%0d want 0/50", d_timeout, d_cycles); end
        ROOT_VALID = 1'b1; ROOT_IN = 34'h1_0000_0001;
        tick();
        ROOT_IN = 34'h1_0000_0002;
        tick();
        ROOT_VALID = 1'b0;
        n_vec++; if (l_valid !== 1'b1 || l_idx !== 2'd0 || l_data !== 34'h0_4248_0000) begin
            n_err++; $display("FAIL to_w0 got v=%b i=%0d d=%h want 1/0/042480000", l_valid, l_idx, l_data); end
        tick(); tick(); tick();
        n_vec++; if (l_done !== 1'b1 || l_cycles !== 24'd49) begin
            n_err++; $display("FAIL to_done got done=%b cyc=%0d want 1/49", l_done, l_cycles); end
    endtask

    task automatic test_edge_vs_limit();
        do_reset();
        BEST_ERROR = 34'h1_1111_1111;
        M_READY = 1'b1;
        go_to(10);
        ROOT_VALID = 1'b1; ROOT_IN = 34'h2_BAD0_0001;
        tick();
        ROOT_VALID = 1'b0;
        go_to(20);
        ROOT_VALID = 1'b1; ROOT_IN = 34'h2_BAD0_0002;
        tick();
        ROOT_VALID = 1'b0;
        go_to(49);
        STOP_TRAINING = 1'b1;
        tick();
        n_vec++; if (l_timeout !== 1'b0 || l_cycles !== 24'd49) begin
            n_err++; $display("FAIL evl_capture got to=%b cyc=%0d want 0/49", l_timeout, l_cycles); end
        ROOT_VALID = 1'b1; ROOT_IN = 34'h1_2222_2222;
        tick();
        ROOT_IN = 34'h1_3333_3333;
        tick();
        ROOT_VALID = 1'b0;
        n_vec++; if (l_valid !== 1'b1 || l_data !== 34'h1_1111_1111) begin
            n_err++; $display("FAIL evl_w0 got v=%b d=%h want 1/111111111", l_valid, l_data); end
        tick();
        n_vec++; if (l_idx !== 2'd1 || l_data !== 34'h1_2222_2222) begin
            n_err++; $display("FAIL evl_w1 got i=%0d d=%h want 1/122222222", l_idx, l_data); end
        tick();
        n_vec++; if (l_idx !== 2'd2 || l_data !== 34'h1_3333_3333 || l_last !== 1'b1) begin
            n_err++; $display("FAIL evl_w2 got i=%0d d=%h l=%b want 2/133333333/1", l_idx, l_data, l_last); end
    endtask

    task automatic test_reset_in_send();
        do_reset();
        go_to(5);
        STOP_TRAINING = 1'b1; BEST_ERROR = 34'h1_5555_0000;
        tick();
        ROOT_VALID = 1'b1; ROOT_IN = 34'h1_6666_0000;
        tick();
        ROOT_IN = 34'h1_7777_0000;
        tick();
        ROOT_VALID = 1'b0; M_READY = 1'b1;
        n_vec++; if (d_valid !== 1'b1 || d_idx !== 2'd0) begin
            n_err++; $display("FAIL rst_send_w0 got v=%b i=%0d want 1/0", d_valid, d_idx); end
        tick();
        RESET = 1'b1;
        tick();
        n_vec++; if (d_valid !== 1'b0 || d_data !== 34'h0 || d_idx !== 2'd0 || d_last !== 1'b0 || d_done !== 1'b0 || d_timeout !== 1'b0 || d_cycles !== 24'd0 || d_bad !== 1'b0) begin
            n_err++; $display("FAIL rst_send_clear got v=%b d=%h i=%0d l=%b done=%b to=%b cyc=%0d bad=%b want all 0", d_valid, d_data, d_idx, d_last, d_done, d_timeout, d_cycles, d_bad); end
        do_reset();
        M_READY = 1'b1;
        go_to(3);
        STOP_TRAINING = 1'b1; BEST_ERROR = 34'h1_0ABC_0000;
        tick();
        ROOT_VALID = 1'b1; ROOT_IN = 34'h0_0000_0000;
        tick();
        ROOT_IN = 34'h1_0DEF_0000;
        tick();
        ROOT_VALID = 1'b0;
        n_vec++; if (d_valid !== 1'b1 || d_data !== 34'h1_0ABC_0000) begin
            n_err++; $display("FAIL fresh_w0 got v=%b d=%h want 1/10abc0000", d_valid, d_data); end
        tick();
        n_vec++; if (d_idx !== 2'd1 || d_data !== 34'h0) begin
            n_err++; $display("FAIL fresh_w1 got i=%0d d=%h want 1/0", d_idx, d_data); end
        tick();
        n_vec++; if (d_idx !== 2'd2 || d_data !== 34'h1_0DEF_0000 || d_last !== 1'b1) begin
            n_err++; $display("FAIL fresh_w2 got i=%0d d=%h l=%b want 2/10def0000/1", d_idx, d_data, d_last); end
        tick();
        n_vec++; if (d_done !== 1'b1 || d_cycles !== 24'd3) begin
            n_err++; $display("FAIL fresh_done got done=%b cyc=%0d want 1/3", d_done, d_cycles); end
    endtask

    task automatic test_bad_result();
        do_reset();
        go_to(3);
        STOP_TRAINING = 1'b1; BEST_ERROR = 34'h1_3A83_126F;
        tick();
        n_vec++; if (d_bad !== 1'b0) begin n_err++; $display("FAIL bad_after_err got %b want 0", d_bad); end
        ROOT_VALID = 1'b1; ROOT_IN = 34'h1_3F80_0000;
        tick();
        n_vec++; if (d_bad !== 1'b0) begin n_err++; $display("FAIL bad_after_root0 got %b want 0", d_bad); end
        ROOT_IN = 34'h3_0000_0000;
        tick();
        ROOT_VALID = 1'b0; M_READY = 1'b1;
        n_vec++; if (d_bad !== EXC_EN) begin n_err++; $display("FAIL bad_after_nan got %b want %b", d_bad, EXC_EN); end
        tick(); tick();
        n_vec++; if (d_data !== 34'h3_0000_0000 || d_last !== 1'b1) begin
            n_err++; $display("FAIL bad_nan_word got d=%h l=%b want 300000000/1", d_data, d_last); end
        tick();
        n_vec++; if (d_done !== 1'b1 || d_bad !== EXC_EN) begin
            n_err++; $display("FAIL bad_held got done=%b bad=%b want 1/%b", d_done, d_bad, EXC_EN); end
    endtask

    initial begin
        test_reset();
        test_single_run();
        test_backpressure();
        test_timeout();
        test_edge_vs_limit();
        test_reset_in_send();
        test_bad_result();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
